// File: rtl/axis_switch_pkg.sv
// Shared definitions for the AXI-Stream splitter/merger family.
package axis_switch_pkg;

  // Default widths shared by the splitter and the merger.
  localparam int DEFAULT_TDATA_WIDTH = 512;
  localparam int DEFAULT_TUSER_WIDTH = 48;
  localparam int DEFAULT_CNT_WIDTH   = 16;

  // Number of ingress ports on the merger.
  localparam int MERGER_PORT_COUNT = 2;

  // Merger arbitration FSM.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } merger_state_t;

  // Two-way round-robin pick. Returns a one-hot grant, or zero when there
  // are no candidates. last_grant: 0 = port 1 was served last, 1 = port 2.
  // On a tie the port that was not served last wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] cand,
                                         input logic       last_grant);
    logic [1:0] pick;
    pick = cand;
    if (cand == 2'b11) begin
      pick = last_grant ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

endpackage : axis_switch_pkg

// File: rtl/axis_reg_slice.sv
// Single-stage forward register slice for an AXI-Stream path.
// Output valid/data come straight from flops; input ready is combinational
// (empty or being drained this cycle), so full throughput is sustained.
module axis_reg_slice
  import axis_switch_pkg::*;
#(
  parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  parameter int TUSER_WIDTH = DEFAULT_TUSER_WIDTH
) (
  input  logic                     aclk_i,
  input  logic                     areset_i,
  input  logic                     s_tvalid_i,
  output logic                     s_tready_o,
  input  logic [TDATA_WIDTH-1:0]   s_tdata_i,
  input  logic [TDATA_WIDTH/8-1:0] s_tkeep_i,
  input  logic                     s_tlast_i,
  input  logic [TUSER_WIDTH-1:0]   s_tuser_i,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [TDATA_WIDTH-1:0]   m_tdata_o,
  output logic [TDATA_WIDTH/8-1:0] m_tkeep_o,
  output logic                     m_tlast_o,
  output logic [TUSER_WIDTH-1:0]   m_tuser_o
);

  logic                     valid_q, valid_d;
  logic [TDATA_WIDTH-1:0]   data_q,  data_d;
  logic [TDATA_WIDTH/8-1:0] keep_q,  keep_d;
  logic                     last_q,  last_d;
  logic [TUSER_WIDTH-1:0]   user_q,  user_d;
  logic                     load;

  assign s_tready_o = ~valid_q | m_tready_i;
  assign load       = s_tvalid_i & s_tready_o;

  // Next state: load on a handshake, drop valid once drained, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    user_d  = user_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = s_tdata_i;
      keep_d  = s_tkeep_i;
      last_d  = s_tlast_i;
      user_d  = s_tuser_i;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register; reset clears the whole beat, not just valid.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;
  assign m_tkeep_o  = keep_q;
  assign m_tlast_o  = last_q;
  assign m_tuser_o  = user_q;

endmodule : axis_reg_slice

// File: rtl/axis_switch_merger_rr.sv
// Two-to-one AXI-Stream packet merger with round-robin arbitration.
// A port is granted in IDLE (one bubble cycle), then owns the egress until
// its tlast beat is accepted, so packets are never interleaved.
module axis_switch_merger_rr
  import axis_switch_pkg::*;
#(
  parameter int TDATA_WIDTH = DEFAULT_TDATA_WIDTH,
  parameter int TUSER_WIDTH = DEFAULT_TUSER_WIDTH,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                     aclk,
  input  logic                     areset,

  input  logic                     s_axis1_tvalid,
  output logic                     s_axis1_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis1_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis1_tkeep,
  input  logic                     s_axis1_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis1_tuser,

  input  logic                     s_axis2_tvalid,
  output logic                     s_axis2_tready,
  input  logic [TDATA_WIDTH-1:0]   s_axis2_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis2_tkeep,
  input  logic                     s_axis2_tlast,
  input  logic [TUSER_WIDTH-1:0]   s_axis2_tuser,

  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic [TUSER_WIDTH-1:0]   m_axis_tuser,

  input  logic [1:0]               port_enable,
  output logic [CNT_WIDTH-1:0]     pkt_count1,
  output logic [CNT_WIDTH-1:0]     pkt_count2,
  output logic [1:0]               active_port
);

  merger_state_t state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_grant_q, last_grant_d;   // 0 = port 1, 1 = port 2

  logic [MERGER_PORT_COUNT-1:0] s_tvalid_vec;
  logic [MERGER_PORT_COUNT-1:0] s_tready_vec;
  logic [1:0]                   cand;
  logic [1:0]                   pick;

  logic                     busy;
  logic                     sel_tvalid;
  logic [TDATA_WIDTH-1:0]   sel_tdata;
  logic [TDATA_WIDTH/8-1:0] sel_tkeep;
  logic                     sel_tlast;
  logic [TUSER_WIDTH-1:0]   sel_tuser;
  logic                     slice_ready;
  logic                     beat_acc;

  assign s_tvalid_vec = {s_axis2_tvalid, s_axis1_tvalid};
  assign busy         = (state_q == BUSY);

  // Enable only gates new grants, so it is looked at only while idle.
  assign cand = s_tvalid_vec & port_enable;
  assign pick = rr_pick(cand, last_grant_q);

  // Steer the granted port into the output slice.
  assign sel_tvalid = busy & (grant_q[1] ? s_axis2_tvalid : s_axis1_tvalid);
  assign sel_tdata  = grant_q[1] ? s_axis2_tdata : s_axis1_tdata;
  assign sel_tkeep  = grant_q[1] ? s_axis2_tkeep : s_axis1_tkeep;
  assign sel_tlast  = grant_q[1] ? s_axis2_tlast : s_axis1_tlast;
  assign sel_tuser  = grant_q[1] ? s_axis2_tuser : s_axis1_tuser;
  assign beat_acc   = sel_tvalid & slice_ready;

  // Per-port ready and packet counter.
  genvar gi;
  generate
    for (gi = 0; gi < MERGER_PORT_COUNT; gi++) begin : g_port
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

      assign s_tready_vec[gi] = busy & grant_q[gi] & slice_ready;
      assign cnt_d = (beat_acc & sel_tlast & grant_q[gi])
                   ? cnt_q + CNT_WIDTH'(1) : cnt_q;

      // Count completed packets; wraps naturally.
      always_ff @(posedge aclk) begin
        if (areset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign s_axis1_tready = s_tready_vec[0];
  assign s_axis2_tready = s_tready_vec[1];
  assign pkt_count1     = g_port[0].cnt_q;
  assign pkt_count2     = g_port[1].cnt_q;
  assign active_port    = busy ? grant_q : 2'b00;

  // Arbitration FSM: grant in IDLE, release on the accepted tlast beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (|cand) begin
          grant_d      = pick;
          last_grant_d = pick[1];
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (beat_acc && sel_tlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // FSM state; port 2 counts as last served so port 1 wins the first tie.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  axis_reg_slice #(
    .TDATA_WIDTH (TDATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH)
  ) u_out_slice (
    .aclk_i     (aclk),
    .areset_i   (areset),
    .s_tvalid_i (sel_tvalid),
    .s_tready_o (slice_ready),
    .s_tdata_i  (sel_tdata),
    .s_tkeep_i  (sel_tkeep),
    .s_tlast_i  (sel_tlast),
    .s_tuser_i  (sel_tuser),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready),
    .m_tdata_o  (m_axis_tdata),
    .m_tkeep_o  (m_axis_tkeep),
    .m_tlast_o  (m_axis_tlast),
    .m_tuser_o  (m_axis_tuser)
  );

endmodule : axis_switch_merger_rr

// File: tb/tb_axis_switch_merger_rr.sv
// Directed bench for the two-to-one round-robin packet merger.
module tb_axis_switch_merger_rr;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          areset;
  logic          s1_tvalid, s1_tready, s1_tlast;
  logic [DW-1:0] s1_tdata;
  logic [3:0]    s1_tkeep;
  logic [UW-1:0] s1_tuser;
  logic          s2_tvalid, s2_tready, s2_tlast;
  logic [DW-1:0] s2_tdata;
  logic [3:0]    s2_tkeep;
  logic [UW-1:0] s2_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tkeep;
  logic [UW-1:0] m_tuser;
  logic [1:0]    en;
  logic [CW-1:0] cnt1, cnt2;
  logic [1:0]    active;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axis_switch_merger_rr #(
    .TDATA_WIDTH (DW),
    .TUSER_WIDTH (UW),
    .CNT_WIDTH   (CW)
  ) dut (
    .aclk           (clk),
    .areset         (areset),
    .s_axis1_tvalid (s1_tvalid),
    .s_axis1_tready (s1_tready),
    .s_axis1_tdata  (s1_tdata),
    .s_axis1_tkeep  (s1_tkeep),
    .s_axis1_tlast  (s1_tlast),
    .s_axis1_tuser  (s1_tuser),
    .s_axis2_tvalid (s2_tvalid),
    .s_axis2_tready (s2_tready),
    .s_axis2_tdata  (s2_tdata),
    .s_axis2_tkeep  (s2_tkeep),
    .s_axis2_tlast  (s2_tlast),
    .s_axis2_tuser  (s2_tuser),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .port_enable    (en),
    .pkt_count1     (cnt1),
    .pkt_count2     (cnt2),
    .active_port    (active)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_m(input string tag, input logic v, input logic [DW-1:0] d, input logic l);
    chk({tag, ".tvalid"}, 64'(m_tvalid), 64'(v));
    chk({tag, ".tdata"},  64'(m_tdata),  64'(d));
    chk({tag, ".tlast"},  64'(m_tlast),  64'(l));
  endtask

  task automatic set1(input logic v, input logic [DW-1:0] d, input logic l);
    s1_tvalid = v; s1_tdata = d; s1_tlast = l; s1_tkeep = 4'hF; s1_tuser = 8'h11;
  endtask

  task automatic set2(input logic v, input logic [DW-1:0] d, input logic l);
    s2_tvalid = v; s2_tdata = d; s2_tlast = l; s2_tkeep = 4'h3; s2_tuser = 8'h22;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run on the falling edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; en = 2'b00; m_tready = 1'b0;
    set1(0, 0, 0); set2(0, 0, 0);
    nxt(); nxt();
    areset = 1'b0;

    // Reset state
    mid();
    chk_m("reset", 0, 0, 0);
    chk("reset.cnt1", 64'(cnt1), 0);
    chk("reset.cnt2", 64'(cnt2), 0);
    chk("reset.active", 64'(active), 0);
    chk("reset.s1_tready", 64'(s1_tready), 0);
    chk("reset.s2_tready", 64'(s2_tready), 0);
    nxt();

    // Port 1 only, 3-beat packet
    m_tready = 1'b1; en = 2'b11;
    set1(1, 32'hA1, 0);
    mid(); chk("t1.grant.active", 64'(active), 0); chk("t1.grant.s1_tready", 64'(s1_tready), 0);
    nxt();
    mid(); chk("t1.busy.s1_tready", 64'(s1_tready), 1); chk("t1.busy.active", 64'(active), 2'b01);
    chk("t1.busy.m_tvalid", 64'(m_tvalid), 0);
    nxt();
    set1(1, 32'hA2, 0);
    mid(); chk_m("t1.beat1", 1, 32'hA1, 0);
    chk("t1.beat1.tkeep", 64'(m_tkeep), 64'h F); chk("t1.beat1.tuser", 64'(m_tuser), 64'h11);
    nxt();
    set1(1, 32'hA3, 1);
    mid(); chk_m("t1.beat2", 1, 32'hA2, 0);
    nxt();
    set1(0, 0, 0);
    mid(); chk_m("t1.beat3", 1, 32'hA3, 1);
    chk("t1.cnt1", 64'(cnt1), 1); chk("t1.active_idle", 64'(active), 0);
    nxt();
    mid(); chk("t1.drain.m_tvalid", 64'(m_tvalid), 0); chk("t1.cnt2", 64'(cnt2), 0);
    nxt();

    // Port 2, 4-beat packet with m_tready 1,0,0,1
    set2(1, 32'hB1, 0);
    nxt();
    mid(); chk("t2.busy.s2_tready", 64'(s2_tready), 1); chk("t2.busy.active", 64'(active), 2'b10);
    nxt();
    set2(1, 32'hB2, 0);
    mid(); chk_m("t2.b1", 1, 32'hB1, 0);
    nxt();
    set2(1, 32'hB3, 0); m_tready = 1'b0;
    mid(); chk_m("t2.stall0", 1, 32'hB2, 0); chk("t2.stall0.s2_tready", 64'(s2_tready), 0);
    nxt();
    mid(); chk_m("t2.stall1", 1, 32'hB2, 0); chk("t2.stall1.s2_tready", 64'(s2_tready), 0);
    nxt();
    m_tready = 1'b1;
    mid(); chk_m("t2.release", 1, 32'hB2, 0); chk("t2.release.s2_tready", 64'(s2_tready), 1);
    nxt();
    set2(1, 32'hB4, 1);
    mid(); chk_m("t2.b3", 1, 32'hB3, 0);
    nxt();
    set2(0, 0, 0);
    mid(); chk_m("t2.b4", 1, 32'hB4, 1);
    chk("t2.b4.tkeep", 64'(m_tkeep), 64'h3); chk("t2.b4.tuser", 64'(m_tuser), 64'h22);
    chk("t2.cnt2", 64'(cnt2), 1);
    nxt();
    mid(); chk("t2.drain.m_tvalid", 64'(m_tvalid), 0);
    nxt();

    // Both ports, 2-beat packets back to back: expect p1,p2,p1,p2
    set1(1, 32'hC1, 0); set2(1, 32'hD1, 0);
    nxt();
    mid(); chk("t3.p1.active", 64'(active), 2'b01); chk("t3.p1.s2_tready", 64'(s2_tready), 0);
    nxt();
    set1(1, 32'hC2, 1);
    mid(); chk_m("t3.c1", 1, 32'hC1, 0);
    nxt();
    set1(1, 32'hC3, 0);
    mid(); chk_m("t3.c2", 1, 32'hC2, 1); chk("t3.gap1.active", 64'(active), 0);
    nxt();
    mid(); chk("t3.bubble1.m_tvalid", 64'(m_tvalid), 0); chk("t3.p2.active", 64'(active), 2'b10);
    chk("t3.p2.s1_tready", 64'(s1_tready), 0);
    nxt();
    set2(1, 32'hD2, 1);
    mid(); chk_m("t3.d1", 1, 32'hD1, 0);
    nxt();
    set2(1, 32'hD3, 0);
    mid(); chk_m("t3.d2", 1, 32'hD2, 1);
    nxt();
    mid(); chk("t3.bubble2.m_tvalid", 64'(m_tvalid), 0); chk("t3.p1b.active", 64'(active), 2'b01);
    nxt();
    set1(1, 32'hC4, 1);
    mid(); chk_m("t3.c3", 1, 32'hC3, 0);
    nxt();
    set1(0, 0, 0);
    mid(); chk_m("t3.c4", 1, 32'hC4, 1);
    nxt();
    mid(); chk("t3.p2b.active", 64'(active), 2'b10);
    nxt();
    set2(1, 32'hD4, 1);
    mid(); chk_m("t3.d3", 1, 32'hD3, 0);
    nxt();
    set2(0, 0, 0);
    mid(); chk_m("t3.d4", 1, 32'hD4, 1);
    chk("t3.cnt1", 64'(cnt1), 3); chk("t3.cnt2", 64'(cnt2), 3);
    nxt();

    // port_enable = 2'b10, then cleared mid-packet
    en = 2'b10;
    set1(1, 32'hE1, 1); set2(1, 32'hF1, 0);
    nxt();
    mid(); chk("t4.active", 64'(active), 2'b10); chk("t4.s1_tready", 64'(s1_tready), 0);
    nxt();
    set2(1, 32'hF2, 0); en = 2'b00;
    mid(); chk_m("t4.f1", 1, 32'hF1, 0);
    nxt();
    set2(1, 32'hF3, 1);
    mid(); chk_m("t4.f2", 1, 32'hF2, 0);
    nxt();
    set2(1, 32'hF9, 0);
    mid(); chk_m("t4.f3", 1, 32'hF3, 1);
    nxt();
    mid(); chk("t4.off.m_tvalid", 64'(m_tvalid), 0); chk("t4.off.active", 64'(active), 0);
    chk("t4.off.s1_tready", 64'(s1_tready), 0); chk("t4.off.s2_tready", 64'(s2_tready), 0);
    chk("t4.cnt1", 64'(cnt1), 3);
    nxt();
    mid(); chk("t4.off2.active", 64'(active), 0); chk("t4.cnt2", 64'(cnt2), 4);
    nxt();
    en = 2'b11; set1(0, 0, 0); set2(0, 0, 0);
    nxt();

    // Reset on the second beat of a 4-beat packet, then a tie
    set1(1, 32'h61, 0);
    nxt();
    mid(); chk("t5.s1_tready", 64'(s1_tready), 1);
    nxt();
    set1(1, 32'h62, 0); areset = 1'b1;
    mid(); chk_m("t5.g1", 1, 32'h61, 0);
    nxt();
    areset = 1'b0; set2(1, 32'h71, 0);
    mid(); chk_m("t5.after_reset", 0, 0, 0);
    chk("t5.cnt1", 64'(cnt1), 0); chk("t5.cnt2", 64'(cnt2), 0);
    chk("t5.active", 64'(active), 0); chk("t5.s1_tready", 64'(s1_tready), 0);
    nxt();
    mid(); chk("t5.tie.active", 64'(active), 2'b01);
    nxt();
    areset = 1'b1; set1(0, 0, 0); set2(0, 0, 0);
    nxt();
    areset = 1'b0;

    // 2^CW+1 single-beat packets on port 2: counter wraps to 1
    for (int i = 0; i < (1 << CW) + 1; i++) begin
      set2(1, DW'(i), 1);
      mid(); chk("t6.idle.s2_tready", 64'(s2_tready), 0);
      if (i == (1 << CW)) chk("t6.wrapped.cnt2", 64'(cnt2), 0);
      nxt();
      mid(); chk("t6.busy.s2_tready", 64'(s2_tready), 1);
      nxt();
    end
    set2(0, 0, 0);
    mid(); chk_m("t6.last", 1, DW'((1 << CW)), 1);
    chk("t6.cnt2", 64'(cnt2), 1);
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_axis_switch_merger_rr
